// File: rtl/thresh_update_sched_if.sv
// rtl/thresh_update_sched_if.sv - entry stream and WISHBONE master bundle for thresh_update_sched
// master is the scheduler side; slave is the servo/threshold-slave side.
interface thresh_update_sched_if;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [5:0]  s_beam_i;
  logic        s_sub_i;
  logic [17:0] s_thresh_i;
  logic        s_last_i;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [11:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;

  modport master (
    input  s_valid_i, s_beam_i, s_sub_i, s_thresh_i, s_last_i,
    output s_ready_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    output s_valid_i, s_beam_i, s_sub_i, s_thresh_i, s_last_i,
    input  s_ready_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/thresh_update_sched.sv
// rtl/thresh_update_sched.sv - WISHBONE master that writes per-beam thresholds, requests an update and polls it
// A poll timeout runs a reset/release recovery on the control register and raises a sticky flag.
module thresh_update_sched #(
  parameter int unsigned NBEAMS       = 46,
  parameter int unsigned POLL_GAP     = 16,
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic wb_clk_i,
  input  logic rst_n_i,
  input  logic enable_i,
  input  logic err_clr_i,
  output logic busy_o,
  output logic update_done_o,
  output logic timeout_o,
  output logic bad_beam_o,
  thresh_update_sched_if.master bus
);

  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [PW-1:0] L_TIMEOUT  = PW'(POLL_TIMEOUT);
  localparam logic [GW-1:0] L_GAP_LAST = GW'(POLL_GAP - 1);
  localparam logic [11:0]   A_SUB      = 12'h400;
  localparam logic [11:0]   A_CTRL     = 12'h800;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_CMD_UPDATE,
    S_POLL_WAIT,
    S_POLL_READ,
    S_RECOVER_ASSERT,
    S_RECOVER_RELEASE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [5:0]    r_beam;
  logic          r_sub;
  logic [17:0]   r_val;
  logic          r_last;
  logic [GW-1:0] r_gap_cnt;
  logic [PW-1:0] r_poll_cnt;
  logic          r_bus_gap;
  logic          r_timeout;
  logic          r_bad_beam;

  logic          w_ready;
  logic          w_accept;
  logic          w_beam_ok;
  logic          w_bus;
  logic          w_cyc;
  logic          w_ack;
  logic          w_pending;
  logic          w_poll_expire;
  logic          w_we;
  logic [11:0]   w_adr;
  logic [31:0]   w_dat;
  logic          w_unused_dat;

  assign w_ready       = (r_state == S_IDLE) & enable_i;
  assign w_accept      = w_ready & bus.s_valid_i;
  assign w_beam_ok     = ({26'd0, bus.s_beam_i} < NBEAMS);
  assign w_bus         = r_state inside {S_WRITE, S_CMD_UPDATE, S_POLL_READ,
                                         S_RECOVER_ASSERT, S_RECOVER_RELEASE};
  // r_bus_gap holds the bus idle for one clock after every ack, so chained accesses never touch.
  assign w_cyc         = w_bus & ~r_bus_gap;
  assign w_ack         = w_cyc & bus.wb_ack_i;
  assign w_pending     = bus.wb_dat_i[1];
  assign w_poll_expire = ((r_poll_cnt + PW'(1)) == L_TIMEOUT);
  assign w_unused_dat  = ^{bus.wb_dat_i[31:2], bus.wb_dat_i[0]};

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_adr  = 12'h000;
    w_dat  = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_beam_ok)          w_next = S_WRITE;
          else if (bus.s_last_i)  w_next = S_CMD_UPDATE;
        end
      end
      S_WRITE: begin
        w_we  = 1'b1;
        w_adr = (r_sub ? A_SUB : 12'h000) | {4'd0, r_beam, 2'b00};
        w_dat = {14'd0, r_val};
        if (w_ack) w_next = r_last ? S_CMD_UPDATE : S_IDLE;
      end
      S_CMD_UPDATE: begin
        w_we  = 1'b1;
        w_adr = A_CTRL;
        w_dat = 32'h2;
        if (w_ack) w_next = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (r_gap_cnt == L_GAP_LAST) w_next = S_POLL_READ;
      end
      S_POLL_READ: begin
        w_adr = A_CTRL;
        if (w_ack) begin
          if (!w_pending)         w_next = S_DONE;
          else if (w_poll_expire) w_next = S_RECOVER_ASSERT;
          else                    w_next = S_POLL_WAIT;
        end
      end
      S_RECOVER_ASSERT: begin
        w_we  = 1'b1;
        w_adr = A_CTRL;
        w_dat = 32'h1;
        if (w_ack) w_next = S_RECOVER_RELEASE;
      end
      S_RECOVER_RELEASE: begin
        w_we  = 1'b1;
        w_adr = A_CTRL;
        w_dat = 32'h0;
        if (w_ack) w_next = S_IDLE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_beam     <= 6'd0;
      r_sub      <= 1'b0;
      r_val      <= 18'd0;
      r_last     <= 1'b0;
      r_gap_cnt  <= '0;
      r_poll_cnt <= '0;
      r_bus_gap  <= 1'b0;
      r_timeout  <= 1'b0;
      r_bad_beam <= 1'b0;
    end else begin
      r_bus_gap <= w_ack;

      if (w_accept) begin
        r_beam <= bus.s_beam_i;
        r_sub  <= bus.s_sub_i;
        r_val  <= bus.s_thresh_i;
        r_last <= bus.s_last_i;
      end

      if (r_state == S_POLL_WAIT) r_gap_cnt <= r_gap_cnt + GW'(1);
      else                        r_gap_cnt <= '0;

      if ((r_state == S_CMD_UPDATE) && w_ack) begin
        r_poll_cnt <= '0;
      end else if ((r_state == S_POLL_READ) && w_ack && w_pending &&
                   (r_poll_cnt != L_TIMEOUT)) begin
        r_poll_cnt <= r_poll_cnt + PW'(1);
      end

      // Clear wins over a set landing on the same edge.
      if (err_clr_i)                                    r_bad_beam <= 1'b0;
      else if (w_accept && !w_beam_ok)                  r_bad_beam <= 1'b1;

      if (err_clr_i)                                    r_timeout <= 1'b0;
      else if ((r_state == S_RECOVER_RELEASE) && w_ack) r_timeout <= 1'b1;
    end
  end

  assign bus.s_ready_o = w_ready;
  assign bus.wb_cyc_o  = w_cyc;
  assign bus.wb_stb_o  = w_cyc;
  assign bus.wb_we_o   = w_cyc & w_we;
  assign bus.wb_adr_o  = w_cyc ? w_adr : 12'h000;
  assign bus.wb_dat_o  = w_cyc ? w_dat : 32'h0;
  assign bus.wb_sel_o  = w_cyc ? 4'hF : 4'h0;

  assign busy_o        = (r_state != S_IDLE);
  assign update_done_o = (r_state == S_DONE);
  assign timeout_o     = r_timeout;
  assign bad_beam_o    = r_bad_beam;

endmodule

// File: tb/tb_thresh_update_sched.sv
// tb/tb_thresh_update_sched.sv - scoreboard bench for thresh_update_sched with a fixed-latency WB slave
// Expected bus accesses are queued when an entry is driven and popped as the slave completes them.
module tb_thresh_update_sched;
  localparam int POLL_GAP     = 5;
  localparam int POLL_TIMEOUT = 4;
  localparam int LAT          = 3;

  typedef struct {
    logic        we;
    logic [11:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          gap;
  } acc_t;

  logic clk;
  logic rst_n;
  logic enable;
  logic err_clr;
  logic busy;
  logic done;
  logic timeout;
  logic bad_beam;

  thresh_update_sched_if bus ();

  thresh_update_sched #(
    .NBEAMS(46),
    .POLL_GAP(POLL_GAP),
    .POLL_TIMEOUT(POLL_TIMEOUT)
  ) dut (
    .wb_clk_i(clk),
    .rst_n_i(rst_n),
    .enable_i(enable),
    .err_clr_i(err_clr),
    .busy_o(busy),
    .update_done_o(done),
    .timeout_o(timeout),
    .bad_beam_o(bad_beam),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  acc_t exp_q[$];
  acc_t obs_q[$];
  logic [31:0] stat_q[$];

  acc_t cur_acc;
  int   ack_cnt = 0;
  bit   in_acc = 0;
  int   neg_idx = 0;
  int   last_ack_idx = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // WB slave: ack after LAT clocks, status reads served from stat_q (0 when empty).
  always @(negedge clk) begin
    neg_idx++;
    if (!rst_n) begin
      bus.wb_ack_i = 1'b0;
      bus.wb_dat_i = 32'h0;
      ack_cnt = 0;
      in_acc = 0;
    end else if (bus.wb_ack_i) begin
      bus.wb_ack_i = 1'b0;
      bus.wb_dat_i = 32'h0;
      obs_q.push_back(cur_acc);
      ack_cnt = 0;
      in_acc = 0;
    end else if (bus.wb_cyc_o && bus.wb_stb_o) begin
      if (!in_acc) begin
        in_acc = 1;
        cur_acc.we  = bus.wb_we_o;
        cur_acc.adr = bus.wb_adr_o;
        cur_acc.dat = bus.wb_dat_o;
        cur_acc.sel = bus.wb_sel_o;
        cur_acc.gap = neg_idx - last_ack_idx - 1;
      end
      if (ack_cnt == LAT - 1) begin
        bus.wb_ack_i = 1'b1;
        last_ack_idx = neg_idx;
        if (!bus.wb_we_o) bus.wb_dat_i = (stat_q.size() != 0) ? stat_q.pop_front() : 32'h0;
      end else begin
        ack_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic acc_t mk(input logic we, input logic [11:0] adr, input logic [31:0] dat);
    acc_t a;
    a.we = we; a.adr = adr; a.dat = dat; a.sel = 4'hF; a.gap = 0;
    return a;
  endfunction

  task automatic send_entry(input logic [5:0] beam, input logic sub, input logic [17:0] val,
                            input logic last, output bit ok);
    ok = 0;
    @(negedge clk); #1;
    bus.s_valid_i = 1'b1; bus.s_beam_i = beam; bus.s_sub_i = sub;
    bus.s_thresh_i = val; bus.s_last_i = last;
    for (int i = 0; i < 200; i++) begin
      if (bus.s_ready_o === 1'b1) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    bus.s_valid_i = 1'b0; bus.s_last_i = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; err_clr = 1'b0;
    bus.s_valid_i = 1'b0; bus.s_beam_i = 6'd0; bus.s_sub_i = 1'b0;
    bus.s_thresh_i = 18'd0; bus.s_last_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o,
         busy, done, timeout, bad_beam} !== 56'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h busy=%b done=%b to=%b bad=%b expected all 0",
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o,
               busy, done, timeout, bad_beam);
    end
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (bus.s_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got %b expected 1", bus.s_ready_o);
    end
  endtask

  task automatic test_single_write();
    bit ok; acc_t e, o; int n;
    exp_q.push_back(mk(1'b1, 12'h00C, 32'h0000_1234));
    send_entry(6'd3, 1'b0, 18'h1234, 1'b0, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL single_accept got %b expected 1", ok); end
    vectors++;
    if ({bus.wb_cyc_o, bus.s_ready_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_latency got cyc=%b ready=%b expected cyc=1 ready=0", bus.wb_cyc_o, bus.s_ready_o);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n = 0;
      while (obs_q.size() == 0 && n < 400) begin @(negedge clk); #1; n++; end
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL single_access got none expected adr=%h", e.adr);
      end else begin
        o = obs_q.pop_front();
        if ({o.we, o.adr, o.dat, o.sel} !== {e.we, e.adr, e.dat, e.sel}) begin
          miscompares++;
          $display("FAIL single_access got we=%b adr=%h dat=%h sel=%h expected we=%b adr=%h dat=%h sel=%h",
                   o.we, o.adr, o.dat, o.sel, e.we, e.adr, e.dat, e.sel);
        end
      end
    end
    vectors++;
    if (bus.s_ready_o !== 1'b1) begin miscompares++; $display("FAIL single_ready_after got %b expected 1", bus.s_ready_o); end
    repeat (30) @(negedge clk);
    #1;
    vectors++;
    if ({obs_q.size() == 0, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_no_ctrl got extra=%0d busy=%b expected 0 extra, busy=0", obs_q.size(), busy);
    end
  endtask

  task automatic test_update_done();
    bit ok; acc_t e, o; int n; int d0;
    d0 = done_cnt;
    stat_q = '{32'h2, 32'h2, 32'h0};
    exp_q.push_back(mk(1'b1, 12'h414, 32'h0003_FFFF));
    exp_q.push_back(mk(1'b1, 12'h800, 32'h2));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 12'h800, 32'h0));
    send_entry(6'd5, 1'b1, 18'h3FFFF, 1'b1, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL upd_accept got %b expected 1", ok); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n = 0;
      while (obs_q.size() == 0 && n < 400) begin @(negedge clk); #1; n++; end
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL upd_access got none expected adr=%h we=%b", e.adr, e.we);
      end else begin
        o = obs_q.pop_front();
        if ({o.we, o.adr, o.dat, o.sel} !== {e.we, e.adr, e.dat, e.sel}) begin
          miscompares++;
          $display("FAIL upd_access got we=%b adr=%h dat=%h sel=%h expected we=%b adr=%h dat=%h sel=%h",
                   o.we, o.adr, o.dat, o.sel, e.we, e.adr, e.dat, e.sel);
        end
        vectors++;
        if (o.gap < (e.we ? 1 : POLL_GAP)) begin
          miscompares++; $display("FAIL upd_gap got %0d idle clks expected >= %0d", o.gap, e.we ? 1 : POLL_GAP);
        end
      end
    end
    n = 0;
    while (busy !== 1'b0 && n < 50) begin @(negedge clk); #1; n++; end
    vectors++;
    if ({done_cnt - d0, timeout} !== {32'd1, 1'b0}) begin
      miscompares++; $display("FAIL upd_done got pulses=%0d timeout=%b expected pulses=1 timeout=0", done_cnt - d0, timeout);
    end
  endtask

  task automatic test_timeout();
    bit ok; acc_t e, o; int n; int d0;
    d0 = done_cnt;
    stat_q = '{32'h2, 32'h2, 32'h2, 32'h2};
    exp_q.push_back(mk(1'b1, 12'h028, 32'h0000_0007));
    exp_q.push_back(mk(1'b1, 12'h800, 32'h2));
    for (int i = 0; i < POLL_TIMEOUT; i++) exp_q.push_back(mk(1'b0, 12'h800, 32'h0));
    exp_q.push_back(mk(1'b1, 12'h800, 32'h1));
    exp_q.push_back(mk(1'b1, 12'h800, 32'h0));
    send_entry(6'd10, 1'b0, 18'h7, 1'b1, ok);
    enable = 1'b0;
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL to_accept got %b expected 1", ok); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n = 0;
      while (obs_q.size() == 0 && n < 400) begin @(negedge clk); #1; n++; end
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL to_access got none expected adr=%h we=%b dat=%h", e.adr, e.we, e.dat);
      end else begin
        o = obs_q.pop_front();
        if ({o.we, o.adr, o.dat, o.sel} !== {e.we, e.adr, e.dat, e.sel}) begin
          miscompares++;
          $display("FAIL to_access got we=%b adr=%h dat=%h sel=%h expected we=%b adr=%h dat=%h sel=%h",
                   o.we, o.adr, o.dat, o.sel, e.we, e.adr, e.dat, e.sel);
        end
        vectors++;
        if (o.gap < (e.we ? 1 : POLL_GAP)) begin
          miscompares++; $display("FAIL to_gap got %0d idle clks expected >= %0d", o.gap, e.we ? 1 : POLL_GAP);
        end
      end
    end
    vectors++;
    if ({busy, timeout, bus.s_ready_o} !== 3'b010) begin
      miscompares++;
      $display("FAIL to_end got busy=%b timeout=%b ready=%b expected busy=0 timeout=1 ready=0", busy, timeout, bus.s_ready_o);
    end
    repeat (20) @(negedge clk);
    #1;
    vectors++;
    if ({done_cnt - d0, obs_q.size()} !== {32'd0, 32'd0}) begin
      miscompares++; $display("FAIL to_quiet got pulses=%0d extra=%0d expected 0 and 0", done_cnt - d0, obs_q.size());
    end
    enable = 1'b1;
  endtask

  task automatic test_bad_beam();
    bit ok; acc_t e, o; int n; int d0;
    @(negedge clk); #1 err_clr = 1'b1;
    @(negedge clk); #1 err_clr = 1'b0;
    vectors++;
    if (timeout !== 1'b0) begin miscompares++; $display("FAIL clr_timeout got %b expected 0", timeout); end
    d0 = done_cnt;
    stat_q = '{32'h0};
    exp_q.push_back(mk(1'b1, 12'h800, 32'h2));
    exp_q.push_back(mk(1'b0, 12'h800, 32'h0));
    send_entry(6'd46, 1'b0, 18'h55, 1'b1, ok);
    vectors++;
    if ({ok, bad_beam} !== 2'b11) begin
      miscompares++; $display("FAIL bad_flag got accept=%b bad=%b expected 1 1", ok, bad_beam);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n = 0;
      while (obs_q.size() == 0 && n < 400) begin @(negedge clk); #1; n++; end
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL bad_access got none expected adr=%h we=%b", e.adr, e.we);
      end else begin
        o = obs_q.pop_front();
        if ({o.we, o.adr, o.dat, o.sel} !== {e.we, e.adr, e.dat, e.sel}) begin
          miscompares++;
          $display("FAIL bad_access got we=%b adr=%h dat=%h sel=%h expected we=%b adr=%h dat=%h sel=%h",
                   o.we, o.adr, o.dat, o.sel, e.we, e.adr, e.dat, e.sel);
        end
      end
    end
    n = 0;
    while (busy !== 1'b0 && n < 50) begin @(negedge clk); #1; n++; end
    vectors++;
    if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL bad_done got pulses=%0d expected 1", done_cnt - d0); end
    @(negedge clk); #1 err_clr = 1'b1;
    @(negedge clk); #1 err_clr = 1'b0;
    vectors++;
    if (bad_beam !== 1'b0) begin miscompares++; $display("FAIL bad_clear got %b expected 0", bad_beam); end
    send_entry(6'd63, 1'b0, 18'h1, 1'b0, ok);
    repeat (10) @(negedge clk);
    #1;
    vectors++;
    if ({bad_beam, busy, obs_q.size() == 0} !== 3'b101) begin
      miscompares++;
      $display("FAIL bad_nolast got bad=%b busy=%b extra=%0d expected bad=1 busy=0 extra=0", bad_beam, busy, obs_q.size());
    end
    @(negedge clk); #1 err_clr = 1'b1;
    @(negedge clk); #1 err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_poll();
    bit ok; bit found; int d0;
    d0 = done_cnt;
    found = 0;
    for (int i = 0; i < 10; i++) stat_q.push_back(32'h2);
    send_entry(6'd1, 1'b0, 18'h99, 1'b1, ok);
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk); #1;
      if (bus.wb_cyc_o === 1'b1 && bus.wb_we_o === 1'b0) found = 1;
    end
    vectors++;
    if (found !== 1'b1) begin miscompares++; $display("FAIL rst_find_read got %b expected 1", found); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_async got cyc=%b stb=%b busy=%b expected 0 0 0", bus.wb_cyc_o, bus.wb_stb_o, busy);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    obs_q.delete(); stat_q.delete();
    @(negedge clk); #1;
    vectors++;
    if ({busy, bus.s_ready_o, bus.wb_cyc_o} !== 3'b010) begin
      miscompares++;
      $display("FAIL rst_idle got busy=%b ready=%b cyc=%b expected 0 1 0", busy, bus.s_ready_o, bus.wb_cyc_o);
    end
    enable = 1'b0;
    #1;
    vectors++;
    if ({bus.s_ready_o, done_cnt - d0} !== {1'b0, 32'd0}) begin
      miscompares++; $display("FAIL rst_ready_en0 got ready=%b pulses=%0d expected 0 0", bus.s_ready_o, done_cnt - d0);
    end
    enable = 1'b1;
  endtask

  task automatic test_clr_priority();
    bit ok; acc_t e, o; int n;
    err_clr = 1'b1;
    stat_q = '{32'h2, 32'h2, 32'h2, 32'h2};
    exp_q.push_back(mk(1'b1, 12'h008, 32'h0000_00AB));
    exp_q.push_back(mk(1'b1, 12'h800, 32'h2));
    for (int i = 0; i < POLL_TIMEOUT; i++) exp_q.push_back(mk(1'b0, 12'h800, 32'h0));
    exp_q.push_back(mk(1'b1, 12'h800, 32'h1));
    exp_q.push_back(mk(1'b1, 12'h800, 32'h0));
    send_entry(6'd2, 1'b0, 18'hAB, 1'b1, ok);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n = 0;
      while (obs_q.size() == 0 && n < 400) begin @(negedge clk); #1; n++; end
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++; $display("FAIL prio_access got none expected adr=%h we=%b", e.adr, e.we);
      end else begin
        o = obs_q.pop_front();
        if ({o.we, o.adr, o.dat, o.sel} !== {e.we, e.adr, e.dat, e.sel}) begin
          miscompares++;
          $display("FAIL prio_access got we=%b adr=%h dat=%h sel=%h expected we=%b adr=%h dat=%h sel=%h",
                   o.we, o.adr, o.dat, o.sel, e.we, e.adr, e.dat, e.sel);
        end
      end
    end
    vectors++;
    if ({timeout, busy} !== 2'b00) begin
      miscompares++; $display("FAIL prio_timeout got timeout=%b busy=%b expected 0 0", timeout, busy);
    end
    err_clr = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (timeout !== 1'b0) begin miscompares++; $display("FAIL prio_after got %b expected 0", timeout); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_update_done();
    test_timeout();
    test_bad_beam();
    test_reset_mid_poll();
    test_clr_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/thresh_update_sched.md
Name: thresh_update_sched

Overview:
- WISHBONE master that sequences threshold programming into the threshold/scaler slave's threshold space.
- Consumes a stream of per-beam threshold entries from the threshold servo. Each entry becomes one WB write.
- At the end of a batch it requests a threshold update, then polls until the aclk-side update completes.
- On poll timeout it runs a reset/release recovery sequence and reports the failure.

Parameters:
NBEAMS, 46, beams present; entries with beam >= NBEAMS are dropped
POLL_GAP, 16, idle clocks between status polls (>=1)
POLL_TIMEOUT, 1024, max status reads before declaring timeout (>=1)

Ports:
wb_clk_i  in  1  clock
rst_n_i  in  1  async active-low reset
enable_i  in  1  allow new entries to be accepted
s_valid_i  in  1  entry valid
s_ready_o  out  1  entry accepted when valid&ready
s_beam_i  in  6  beam index
s_sub_i  in  1  0=trigger threshold, 1=subthreshold
s_thresh_i  in  18  threshold value
s_last_i  in  1  final entry of batch; triggers update
wb_cyc_o / wb_stb_o / wb_we_o  out  1  WB master strobes
wb_adr_o  out  12  byte address
wb_dat_o  out  32  write data
wb_sel_o  out  4  byte selects, always 4'hF
wb_ack_i  in  1  WB ack
wb_dat_i  in  32  WB read data
busy_o  out  1  state != IDLE
update_done_o  out  1  1-clk pulse: update completed
timeout_o  out  1  sticky: poll timeout occurred
bad_beam_o  out  1  sticky: out-of-range beam dropped
err_clr_i  in  1  clears timeout_o and bad_beam_o

Behaviour:
- Clocking and reset
  - Single clock wb_clk_i. Reset is asynchronous and active-low on rst_n_i.
  - During reset: state=IDLE; all WB outputs 0; busy_o, update_done_o, timeout_o, bad_beam_o all 0; counters 0.
  - Reset asserted mid-transaction drops cyc/stb immediately. No completion pulse is issued.
- Address map (fixed)
  - Trigger threshold for beam b: 12'h000 + 4*b.
  - Subthreshold for beam b: 12'h400 + 4*b.
  - Threshold control: 12'h800. Bit0 = reset_update, bit1 = update_request. Read bit1 = update still pending.
- Entry handshake
  - s_ready_o = (state==IDLE) & enable_i.
  - On acceptance, beam, sub, value and last are latched.
  - If beam >= NBEAMS: set bad_beam_o and perform no write. If last is set, go to CMD_UPDATE; otherwise return to IDLE.
- WB outputs
  - All WB outputs are decodes of registered state/holding registers; no combinational path from wb_ack_i.
  - cyc=stb=1 in every bus state until ack. The ack is consumed on its clock edge, so cyc/stb are low the following cycle.
  - Each access is a single classic cycle; the bus is idle at least 1 clk between accesses.
- State machine
  - IDLE: accept entry -> WRITE, or CMD_UPDATE if bad beam with last, or stay IDLE if bad beam without last.
  - WRITE: we=1, adr per map, dat={14'b0,value}. On ack: last -> CMD_UPDATE, else IDLE.
  - CMD_UPDATE: write 32'h2 to 12'h800. On ack: clear poll count -> POLL_WAIT.
  - POLL_WAIT: count POLL_GAP clocks -> POLL_READ.
  - POLL_READ: we=0, adr 12'h800. On ack, the read is evaluated:
    - wb_dat_i[1]==0 -> DONE.
    - Otherwise increment poll count; if count == POLL_TIMEOUT -> RECOVER_ASSERT, else POLL_WAIT.
  - RECOVER_ASSERT: write 32'h1 to 12'h800 (reset asserted, request cleared). On ack -> RECOVER_RELEASE.
  - RECOVER_RELEASE: write 32'h0 to 12'h800. On ack: set timeout_o -> IDLE. No done pulse is issued.
  - DONE: update_done_o=1 for exactly this clock -> IDLE.
- Sticky flags
  - err_clr_i has priority over a simultaneous set; the flag is 0 the next cycle.
  - Setting a flag does not stall the FSM.
- Other rules
  - enable_i deasserted mid-batch only blocks new entries; the in-flight access and any pending update sequence complete.
  - The poll counter saturates at POLL_TIMEOUT and is sized with $clog2(POLL_TIMEOUT+1).
  - Latency: accept -> cyc high next clk.

Test Plan:
- Entry beam=3, sub=0, val=18'h1234, last=0, fixed 3-clk ack latency -> one write adr 0x00C, dat 0x00001234, sel F. s_ready_o low until the cycle after ack; no control writes.
- Entry beam=5, sub=1, val=18'h3FFFF, last=1; status read returns 0x2 twice then 0x0 -> write adr 0x414, dat 0x3FFFF. Then write 0x800/0x2, then 3 reads spaced by >=POLL_GAP idle clks, then a 1-clk update_done_o pulse.
- POLL_TIMEOUT=4, status always 0x2 -> exactly 4 reads, then writes 0x800/0x1 and 0x800/0x0. timeout_o=1, update_done_o never pulses, busy_o drops after the release ack.
- Entry beam=46, last=1 -> no threshold write, bad_beam_o=1, update sequence still runs. err_clr_i pulse -> bad_beam_o=0.
- rst_n_i low while POLL_READ has cyc high -> cyc/stb/busy_o go 0 asynchronously. After release the FSM is in IDLE and s_ready_o=enable_i.
- err_clr_i asserted on the same clk as timeout set -> timeout_o stays 0.
